// File: rtl/note_pkg.sv
// Shared constants, FSM state type and sizing helper for the note table writer.
// Optional build macro: NOTE_WR_CHECKSUM_EN (trailing XOR check byte per frame).
package note_pkg;

   localparam int         NOTE_DATA_WIDTH = 38;
   localparam int         NOTE_ADDR_WIDTH = 6;
   localparam logic [7:0] NOTE_HDR_BYTE   = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      COUNT,
      DATA,
      CHECK,
      DONE,
      ERR
   } state_t;

   // Whole bytes needed to carry one entry of the given bit width.
   function automatic int bytes_per_entry(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/note_entry_assembler.sv
// Little-endian byte-to-entry assembler: collects bytes and emits a registered
// entry with a one-cycle entry_valid strobe the cycle after the last byte.
module note_entry_assembler #(
   parameter int DATA_W = note_pkg::NOTE_DATA_WIDTH
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   input  logic              first,
   input  logic              last,
   output logic [DATA_W-1:0] entry,
   output logic              entry_valid
);
   import note_pkg::*;

   localparam int SR_W = bytes_per_entry(DATA_W) * 8;

   // Earlier bytes of the entry; new bytes enter at the top so byte 0 ends up in [7:0].
   logic [SR_W-9:0] prev_q;
   logic [SR_W-1:0] full;

   always_comb begin
      full = {byte_data, (first ? {(SR_W-8){1'b0}} : prev_q)};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_q      <= '0;
         entry       <= '0;
         entry_valid <= 1'b0;
      end else begin
         entry_valid <= byte_valid & last;
         if (byte_valid) begin
            prev_q <= full[SR_W-1:8];
         end
         if (byte_valid && last) begin
            entry <= full[DATA_W-1:0];
         end
      end
   end

endmodule

// File: rtl/note_table_writer.sv
// Framed byte-stream loader for the per-key note RAMs: A5, KEY, COUNT, entries[, CHECK].
// Optional build macro: NOTE_WR_CHECKSUM_EN adds the CHECK byte and its XOR accumulator.
module note_table_writer #(
   parameter int NOTE_DATA_WIDTH = note_pkg::NOTE_DATA_WIDTH,
   parameter int NOTE_ADDR_WIDTH = note_pkg::NOTE_ADDR_WIDTH
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [7:0]                 cfg_data,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic                       wr_en,
   output logic [1:0]                 wr_bank,
   output logic [NOTE_ADDR_WIDTH-1:0] wr_addr,
   output logic [NOTE_DATA_WIDTH-1:0] wr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output note_pkg::state_t           dbg_state
);
   import note_pkg::*;

   // Handshake: a byte transfers on every rising clock edge where cfg_valid and
   // cfg_ready are both high; cfg_valid low simply holds the FSM where it is.

   localparam int BPE   = bytes_per_entry(NOTE_DATA_WIDTH);
   localparam int IDX_W = $clog2(BPE + 1);
   localparam int DEPTH = 1 << NOTE_ADDR_WIDTH;

   state_t                     state, state_next;
   logic [IDX_W-1:0]           byte_idx;
   logic [NOTE_ADDR_WIDTH:0]   remaining;
   logic [NOTE_ADDR_WIDTH-1:0] addr;
   logic [1:0]                 bank;
   logic                       accept;
   logic                       entry_last;
   logic                       count_bad;

   assign accept     = cfg_valid & cfg_ready;
   assign entry_last = (state == DATA) && accept && (byte_idx == IDX_W'(BPE - 1));
   assign count_bad  = (cfg_data == 8'd0) || ({1'b0, cfg_data} > 9'(DEPTH));

`ifdef NOTE_WR_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         csum <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            csum <= '0;
         end else if (state == KEY || state == COUNT || state == DATA) begin
            csum <= csum ^ cfg_data;
         end
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept && cfg_data == NOTE_HDR_BYTE) state_next = KEY;
         KEY:   if (accept) state_next = COUNT;
         COUNT: if (accept) state_next = count_bad ? ERR : DATA;
         DATA: begin
            if (entry_last && remaining == (NOTE_ADDR_WIDTH+1)'(1)) begin
`ifdef NOTE_WR_CHECKSUM_EN
               state_next = CHECK;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef NOTE_WR_CHECKSUM_EN
         CHECK: if (accept) state_next = (cfg_data == csum) ? DONE : ERR;
`endif
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = !(state == DONE || state == ERR);
      busy      = (state == KEY) || (state == COUNT) || (state == DATA) || (state == CHECK);
      done      = (state == DONE);
      error     = (state == ERR);
      dbg_state = state;
   end

   // Frame counters; wr_bank/wr_addr are captured alongside the assembled entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bank      <= '0;
         remaining <= '0;
         addr      <= '0;
         byte_idx  <= '0;
         wr_bank   <= '0;
         wr_addr   <= '0;
      end else if (accept) begin
         case (state)
            KEY: bank <= cfg_data[1:0];
            COUNT: begin
               remaining <= (NOTE_ADDR_WIDTH+1)'(cfg_data);
               addr      <= '0;
               byte_idx  <= '0;
            end
            DATA: begin
               if (entry_last) begin
                  byte_idx  <= '0;
                  wr_addr   <= addr;
                  wr_bank   <= bank;
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   note_entry_assembler #(
      .DATA_W (NOTE_DATA_WIDTH)
   ) u_assembler (
      .clock       (clock),
      .reset_n     (reset_n),
      .byte_data   (cfg_data),
      .byte_valid  (accept && state == DATA),
      .first       (byte_idx == '0),
      .last        (entry_last),
      .entry       (wr_data),
      .entry_valid (wr_en)
   );

endmodule
